// File: rtl/shader_tri_sequencer.sv
// Avalon-MM triangle table that streams slots 0..COUNT-1 to the shader core
// over a 4-phase start/done handshake, with optional continuous loop mode.
module shader_tri_sequencer #(
    parameter int NUM_TRI = 4,
    parameter int COORD_W = 16,
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic               write,
    input  logic               read,
    input  logic [7:0]         address,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq,
    output logic               start,
    input  logic               done,
    output logic [4:0]         tri_idx,
    output logic [COORD_W-1:0] v1x,
    output logic [COORD_W-1:0] v1y,
    output logic [COORD_W-1:0] v2x,
    output logic [COORD_W-1:0] v2y,
    output logic [COORD_W-1:0] v3x,
    output logic [COORD_W-1:0] v3y
);

    localparam logic [7:0] ADDR_CTRL   = 8'hF0;
    localparam logic [7:0] ADDR_COUNT  = 8'hF1;
    localparam logic [7:0] ADDR_STATUS = 8'hF2;
    localparam logic [7:0] ADDR_FRAME  = 8'hF3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_ACK,
        S_NEXT
    } state_t;

    state_t               state, next_state;
    logic [COORD_W-1:0]   tri_tbl [NUM_TRI][6];
    logic [COORD_W-1:0]   vtx     [6];
    logic [COORD_W-1:0]   slot_vtx[6];
    logic [4:0]           idx, idx_d;
    logic [5:0]           idx_inc;
    logic [4:0]           count;
    logic                 irq_en, loop_en, done_sticky;
    logic [FRAME_W-1:0]   frame_cnt;
    logic                 wr_en, rd_en, go, busy;
    logic                 set_done, frame_inc, clr_done;
    logic [15:0]          rd_mux;

    assign wr_en    = chipselect & write;
    assign rd_en    = chipselect & read;
    assign go       = wr_en && (address == ADDR_CTRL) && writedata[0];
    assign clr_done = wr_en && (address == ADDR_STATUS) && writedata[1];
    assign busy     = (state != S_IDLE);
    assign idx_inc  = {1'b0, idx} + 6'd1;
    assign irq      = done_sticky & irq_en;

    assign v1x = vtx[0];
    assign v1y = vtx[1];
    assign v2x = vtx[2];
    assign v2y = vtx[3];
    assign v3x = vtx[4];
    assign v3y = vtx[5];

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        idx_d      = idx;
        set_done   = 1'b0;
        frame_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (count != '0) begin
                        next_state = S_LOAD;
                        idx_d      = '0;
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            S_LOAD: next_state = S_REQ;
            S_REQ:  if (done)  next_state = S_ACK;
            S_ACK:  if (!done) next_state = S_NEXT;
            S_NEXT: begin
                if (idx_inc < {1'b0, count}) begin
                    next_state = S_LOAD;
                    idx_d      = idx_inc[4:0];
                end else begin
                    set_done  = 1'b1;
                    frame_inc = 1'b1;
                    if (loop_en) begin
                        next_state = S_LOAD;
                        idx_d      = '0;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Slot selector; compares against each slot so idx never indexes past the table.
    always_comb begin
        for (int f = 0; f < 6; f++) slot_vtx[f] = '0;
        for (int t = 0; t < NUM_TRI; t++) begin
            if (idx == 5'(t)) begin
                for (int f = 0; f < 6; f++) slot_vtx[f] = tri_tbl[t][f];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:   rd_mux = {13'd0, loop_en, irq_en, 1'b0};
            ADDR_COUNT:  rd_mux = 16'(count);
            ADDR_STATUS: rd_mux = {14'd0, done_sticky, busy};
            ADDR_FRAME:  rd_mux = 16'(frame_cnt);
            default: begin
                for (int t = 0; t < NUM_TRI; t++) begin
                    for (int f = 0; f < 6; f++) begin
                        if (address == 8'(8 * t + f)) rd_mux = 16'(tri_tbl[t][f]);
                    end
                end
            end
        endcase
    end

    // NOTE: state and all registered outputs use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // start is registered from next_state so it rises together with the vertex snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            start   <= 1'b0;
            tri_idx <= '0;
            for (int f = 0; f < 6; f++) vtx[f] <= '0;
        end else begin
            idx   <= idx_d;
            start <= (next_state == S_REQ);
            if (state == S_LOAD) begin
                tri_idx <= idx;
                for (int f = 0; f < 6; f++) vtx[f] <= slot_vtx[f];
            end
        end
    end

    // NOTE: the vertex table is reset deliberately; software relies on it reading back as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TRI; t++) begin
                for (int f = 0; f < 6; f++) tri_tbl[t][f] <= '0;
            end
            irq_en      <= 1'b0;
            loop_en     <= 1'b0;
            count       <= '0;
            done_sticky <= 1'b0;
            frame_cnt   <= '0;
            readdata    <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_CTRL: begin
                        irq_en  <= writedata[1];
                        loop_en <= writedata[2];
                    end
                    ADDR_COUNT: begin
                        if (writedata > 16'(NUM_TRI)) count <= 5'(NUM_TRI);
                        else                          count <= writedata[4:0];
                    end
                    default: begin
                        for (int t = 0; t < NUM_TRI; t++) begin
                            for (int f = 0; f < 6; f++) begin
                                if (address == 8'(8 * t + f))
                                    tri_tbl[t][f] <= writedata[COORD_W-1:0];
                            end
                        end
                    end
                endcase
            end
            // A set from the sequencer beats a simultaneous software clear.
            if (set_done)      done_sticky <= 1'b1;
            else if (clr_done) done_sticky <= 1'b0;
            if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
            readdata <= rd_en ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_shader_tri_sequencer.sv
// Self-checking bench for shader_tri_sequencer: register vectors, hand-timed
// handshake corners and randomized passes against a table/queue model.
module tb_shader_tri_sequencer;

    localparam int NUM_TRI = 4;

    logic        clk = 1'b0;
    logic        reset, chipselect, write, read;
    logic [7:0]  address;
    logic [15:0] writedata, readdata;
    logic        irq, start, done;
    logic [4:0]  tri_idx;
    logic [15:0] v1x, v1y, v2x, v2y, v3x, v3y;

    logic done_man, done_auto;
    assign done = done_man | done_auto;

    shader_tri_sequencer #(.NUM_TRI(NUM_TRI), .COORD_W(16), .FRAME_W(16)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
        .start(start), .done(done), .tri_idx(tri_idx),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [95:0] v;
    } obs_t;
    obs_t seen[$];
    int   pulses = 0;

    logic [15:0] mdl [NUM_TRI][6];
    int          frame_exp = 0;
    bit          auto_ack = 0;
    int          ack_delay = 5;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] slot_exp(input int t);
        return {mdl[t][0], mdl[t][1], mdl[t][2], mdl[t][3], mdl[t][4], mdl[t][5]};
    endfunction

    // Shader stand-in: raises done ack_delay cycles after start, drops it once start falls.
    initial begin
        int wait_cnt = 0;
        done_auto = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!auto_ack) begin
                done_auto = 1'b0;
                wait_cnt  = 0;
            end else if (done_auto) begin
                if (!start) done_auto = 1'b0;
            end else if (start) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    done_auto = 1'b1;
                    wait_cnt  = 0;
                end
            end
        end
    end

    // Records the triangle presented at every rising edge of start.
    initial begin
        logic start_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start && !start_prev) begin
                obs_t o;
                o.idx = tri_idx;
                o.v   = {v1x, v1y, v2x, v2y, v3x, v3y};
                seen.push_back(o);
                pulses++;
            end
            start_prev = start;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic tbl_write(input int t, input int f, input logic [15:0] d);
        bus_write(8'(8 * t + f), d);
        mdl[t][f] = d;
    endtask

    task automatic wait_idle(input string name);
        logic [15:0] st;
        int n = 0;
        st = 16'h1;
        while (st[0] && n < 500) begin
            bus_read(8'hF2, st);
            n++;
        end
        check({name, " idle"}, 96'(st[0]), 96'(0));
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(name, 96'(d), 96'(exp));
    endtask

    // One non-looping pass; expectation comes from the model table and clamped count.
    task automatic run_pass(input int cnt, input string tag);
        int eff, base;
        eff  = (cnt > NUM_TRI) ? NUM_TRI : cnt;
        base = seen.size();
        bus_write(8'hF2, 16'h2);
        bus_write(8'hF1, 16'(cnt));
        bus_write(8'hF0, 16'h1);
        wait_idle(tag);
        check({tag, " pulses"}, 96'(seen.size() - base), 96'(eff));
        for (int i = 0; i < eff && base + i < seen.size(); i++) begin
            check({tag, " idx"}, 96'(seen[base + i].idx), 96'(i));
            check({tag, " vtx"}, seen[base + i].v, slot_exp(i));
        end
        if (eff > 0) frame_exp++;
        read_check({tag, " frame"}, 8'hF3, 16'(frame_exp));
        read_check({tag, " status"}, 8'hF2, 16'h2);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int          base, cyc, total;
        logic [15:0] old_v, new_v, d;

        vecs[0]  = '{8'h00, 16'h1234, 16'h1234};
        vecs[1]  = '{8'h05, 16'hBEEF, 16'hBEEF};
        vecs[2]  = '{8'h06, 16'h5555, 16'h0000};
        vecs[3]  = '{8'h07, 16'hAAAA, 16'h0000};
        vecs[4]  = '{8'h1D, 16'h0F0F, 16'h0F0F};
        vecs[5]  = '{8'h20, 16'h1111, 16'h0000};
        vecs[6]  = '{8'hF1, 16'h0002, 16'h0002};
        vecs[7]  = '{8'hF1, 16'h0009, 16'h0004};
        vecs[8]  = '{8'hF1, 16'hFFFF, 16'h0004};
        vecs[9]  = '{8'hF0, 16'h0006, 16'h0006};
        vecs[10] = '{8'hF3, 16'h0055, 16'h0000};
        vecs[11] = '{8'hF0, 16'h0000, 16'h0000};

        for (int t = 0; t < NUM_TRI; t++)
            for (int f = 0; f < 6; f++) mdl[t][f] = '0;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; done_man = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst start", 96'(start), 96'(0));
        check("rst irq", 96'(irq), 96'(0));
        check("rst readdata", 96'(readdata), 96'(0));
        check("rst vtx", {v1x, v1y, v2x, v2y, v3x, v3y, 11'd0, tri_idx}, 96'(0));
        @(negedge clk); reset = 1'b0;
        read_check("rst status", 8'hF2, 16'h0);
        read_check("rst count", 8'hF1, 16'h0);
        read_check("rst frame", 8'hF3, 16'h0);
        read_check("rst table", 8'h0A, 16'h0);

        // Register map vectors: write, then read back.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] a;
            a = vecs[i].addr;
            bus_write(a, vecs[i].wdata);
            if (a < 8'(8 * NUM_TRI) && a[2:0] < 3'd6) mdl[a[7:3]][a[2:0]] = vecs[i].wdata;
            read_check($sformatf("vec%0d", i), a, vecs[i].exp);
        end

        // Single triangle with hand-driven done and exact latency.
        tbl_write(0, 0, 16'h0904); tbl_write(0, 1, 16'h0b77); tbl_write(0, 2, 16'h19ce);
        tbl_write(0, 3, 16'h0f9c); tbl_write(0, 4, 16'h06e9); tbl_write(0, 5, 16'h238f);
        bus_write(8'hF1, 16'h1);
        bus_write(8'hF0, 16'h1);
        check("lat load start", 96'(start), 96'(0));
        @(posedge clk); #1;
        check("lat start", 96'(start), 96'(1));
        check("lat vtx", {v1x, v1y, v2x, v2y, v3x, v3y}, slot_exp(0));
        check("lat idx", 96'(tri_idx), 96'(0));
        repeat (3) @(posedge clk);
        #1;
        check("start held", 96'(start), 96'(1));
        done_man = 1'b1;
        @(posedge clk); #1;
        check("start drop", 96'(start), 96'(0));
        done_man = 1'b0;
        wait_idle("single");
        frame_exp++;
        read_check("single status", 8'hF2, 16'h2);
        read_check("single frame", 8'hF3, 16'(frame_exp));

        // Three triangles, shader acks after 5 cycles.
        auto_ack = 1; ack_delay = 5;
        run_pass(3, "count3");

        // Randomized passes against the model.
        for (int r = 0; r < 6; r++) begin
            for (int t = 0; t < NUM_TRI; t++)
                for (int f = 0; f < 6; f++) tbl_write(t, f, 16'($urandom));
            ack_delay = $urandom_range(1, 6);
            run_pass($urandom_range(0, 6), $sformatf("rand%0d", r));
        end

        // Loop mode: runs until LOOP is cleared, finishing the pass in progress.
        ack_delay = 1;
        base = seen.size();
        bus_write(8'hF1, 16'h2);
        bus_write(8'hF0, 16'h5);
        cyc = 0;
        while (seen.size() - base < 6 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check("loop ran", 96'(seen.size() - base >= 6), 96'(1));
        bus_write(8'hF0, 16'h0);
        wait_idle("loop");
        total = seen.size() - base;
        check("loop whole passes", 96'(total % 2), 96'(0));
        for (int i = 0; i < total; i++)
            check("loop idx", 96'(seen[base + i].idx), 96'(i % 2));
        frame_exp += total / 2;
        read_check("loop frame", 8'hF3, 16'(frame_exp));
        auto_ack = 0;

        // Table write during REQ must not disturb the snapshot; GO while busy ignored.
        base = seen.size();
        bus_write(8'hF1, 16'h1);
        bus_write(8'hF0, 16'h1);
        @(posedge clk); #1;
        old_v = mdl[0][0];
        check("snap before", 96'(v1x), 96'(old_v));
        new_v = old_v ^ 16'h00FF;
        tbl_write(0, 0, new_v);
        check("snap held", 96'(v1x), 96'(old_v));
        bus_write(8'hF0, 16'h1);
        done_man = 1'b1;
        cyc = 0;
        while (start && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        done_man = 1'b0;
        wait_idle("busy go");
        frame_exp++;
        check("busy go pulses", 96'(seen.size() - base), 96'(1));
        bus_write(8'hF0, 16'h1);
        @(posedge clk); #1;
        check("snap reload", 96'(v1x), 96'(new_v));
        done_man = 1'b1;
        repeat (2) @(posedge clk);
        done_man = 1'b0;
        wait_idle("reload");
        frame_exp++;

        // done already high when REQ is entered: start still pulses one cycle.
        base = seen.size();
        done_man = 1'b1;
        bus_write(8'hF0, 16'h1);
        @(posedge clk); #1;
        check("early done start", 96'(start), 96'(1));
        @(posedge clk); #1;
        check("early done drop", 96'(start), 96'(0));
        done_man = 1'b0;
        wait_idle("early done");
        frame_exp++;
        check("early done pulses", 96'(seen.size() - base), 96'(1));
        read_check("early done frame", 8'hF3, 16'(frame_exp));

        // Set of done_sticky in the same cycle as a software clear: set wins.
        bus_write(8'hF2, 16'h2);
        bus_write(8'hF0, 16'h1);
        @(posedge clk); #1;
        @(negedge clk); done_man = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); done_man = 1'b0;
        @(posedge clk); #1;
        bus_write(8'hF2, 16'h2);
        frame_exp++;
        read_check("set wins", 8'hF2, 16'h2);

        // COUNT=0 with IRQ_EN: immediate irq, no start, W1C clears it.
        base = pulses;
        bus_write(8'hF2, 16'h2);
        bus_write(8'hF1, 16'h0);
        bus_write(8'hF0, 16'h3);
        check("cnt0 irq", 96'(irq), 96'(1));
        repeat (5) @(posedge clk);
        #1;
        check("cnt0 no start", 96'(pulses - base), 96'(0));
        read_check("cnt0 status", 8'hF2, 16'h2);
        bus_write(8'hF2, 16'h2);
        check("cnt0 irq clr", 96'(irq), 96'(0));
        read_check("cnt0 frame", 8'hF3, 16'(frame_exp));

        // Reset in the middle of a handshake.
        bus_write(8'hF1, 16'h1);
        bus_write(8'hF0, 16'h1);
        @(posedge clk); #1;
        check("pre-rst start", 96'(start), 96'(1));
        bus_read(8'h01, d);
        check("pre-rst read", 96'(d), 96'(mdl[0][1]));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("mid rst start", 96'(start), 96'(0));
        check("mid rst readdata", 96'(readdata), 96'(0));
        check("mid rst vtx", 96'(v1x), 96'(0));
        @(negedge clk); reset = 1'b0;
        read_check("mid rst frame", 8'hF3, 16'h0);
        read_check("mid rst table", 8'h01, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
